// File: rtl/sram_port_arbiter_pkg.sv
// Shared definitions for the SRAM port arbiter.
//   SRC_INST / SRC_DATA : owner identifiers stored per outstanding transaction
//   owner_t             : owner FIFO entry {src, discard}
package sram_port_arbiter_pkg;

  localparam logic SRC_INST = 1'b0;
  localparam logic SRC_DATA = 1'b1;

  typedef struct packed {
    logic src;      // which requester owns the response
    logic discard;  // fetch killed by a flush: swallow its response
  } owner_t;

endpackage

// File: rtl/arb_owner_fifo.sv
// In-order owner tracker for accepted shared-port transactions.
// Ports:
//   clk, resetn      clock, synchronous active-low reset
//   push, push_entry append a newly accepted transaction
//   pop              retire the head (response returned)
//   flush            mark every fetch entry (stored or pushed now) as discard
//   full, empty      occupancy status
//   head             oldest outstanding entry
module arb_owner_fifo
  import sram_port_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic   clk,
  input  logic   resetn,
  input  logic   push,
  input  owner_t push_entry,
  input  logic   pop,
  input  logic   flush,
  output logic   full,
  output logic   empty,
  output owner_t head
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  owner_t        entries [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          pop_ok;
  logic          push_ok;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign head  = entries[rd_ptr];

  // A pop frees a slot in the same cycle, so a full FIFO may take a push then.
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  // Pointers are log2(DEPTH) wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Payload needs no reset: only slots inside [rd_ptr, wr_ptr) are ever read.
  // Marking free slots on flush is harmless; they are overwritten on push.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (flush && entries[i].src == SRC_INST) entries[i].discard <= 1'b1;
    end
    if (push_ok) begin
      entries[wr_ptr].src     <= push_entry.src;
      entries[wr_ptr].discard <= push_entry.discard |
                                 (flush & (push_entry.src == SRC_INST));
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Arbitrates an instruction-fetch port and a MEM-stage data port onto one
// shared SRAM-like port with split address/data handshakes. Responses come
// back in acceptance order and are steered using an owner FIFO.
// Ports:
//   clk, resetn                 clock, synchronous active-low reset
//   inst_*                      fetch requester (read only)
//   data_*                      MEM-stage requester (read/write)
//   flush                       pipeline flush pulse: kills in-flight fetches
//   mem_*                       shared port toward the memory
// Parameter OUTS_DEPTH: max outstanding accepted transactions (2,4,8).
// Macro ARB_RR_EN: when defined, ties alternate round-robin (starting with
// data); otherwise data always beats fetch.
module sram_port_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter int OUTS_DEPTH = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  input  logic        flush,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  // Request held on the port while mem_addr_ok is pending.
  logic        lock_q;
  logic        lock_src_q;
  logic        lock_wr_q;
  logic [3:0]  lock_wstrb_q;
  logic [31:0] lock_addr_q;
  logic [31:0] lock_wdata_q;

  logic        inst_elig;
  logic        tie_src;
  logic        grant_any;
  logic        grant_src;
  logic        req_wr;
  logic [3:0]  req_wstrb;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        fifo_full;
  logic        fifo_empty;
  owner_t      head;
  owner_t      push_entry;
  logic        room;
  logic        issue;
  logic        accept;
  logic        pop;

  // A flush cycle must not start a new fetch.
  assign inst_elig = inst_req & ~flush;

`ifdef ARB_RR_EN
  // Source favoured on the next tie; flips to the other side on every accept.
  logic rr_q;

  always_ff @(posedge clk) begin
    if (!resetn)     rr_q <= SRC_DATA;
    else if (accept) rr_q <= ~grant_src;
  end

  assign tie_src = rr_q;
`else
  assign tie_src = SRC_DATA;
`endif

  always_comb begin
    grant_any = 1'b0;
    grant_src = SRC_DATA;
    if (lock_q) begin
      grant_any = 1'b1;
      grant_src = lock_src_q;
    end else if (data_req && inst_elig) begin
      grant_any = 1'b1;
      grant_src = tie_src;
    end else if (data_req) begin
      grant_any = 1'b1;
      grant_src = SRC_DATA;
    end else if (inst_elig) begin
      grant_any = 1'b1;
      grant_src = SRC_INST;
    end
  end

  always_comb begin
    req_wr    = data_wr;
    req_wstrb = data_wstrb;
    req_addr  = data_addr;
    req_wdata = data_wdata;
    if (lock_q) begin
      req_wr    = lock_wr_q;
      req_wstrb = lock_wstrb_q;
      req_addr  = lock_addr_q;
      req_wdata = lock_wdata_q;
    end else if (grant_src == SRC_INST) begin
      req_wr    = 1'b0;
      req_wstrb = 4'h0;
      req_addr  = inst_addr;
      req_wdata = 32'h0;
    end
  end

  // A response retiring this cycle makes room for a new acceptance.
  assign room   = ~fifo_full | mem_data_ok;
  assign issue  = resetn & grant_any & room;
  assign accept = issue & mem_addr_ok;
  assign pop    = resetn & mem_data_ok & ~fifo_empty;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      lock_q       <= 1'b0;
      lock_src_q   <= SRC_DATA;
      lock_wr_q    <= 1'b0;
      lock_wstrb_q <= 4'h0;
      lock_addr_q  <= 32'h0;
      lock_wdata_q <= 32'h0;
    end else if (accept) begin
      lock_q <= 1'b0;
    end else if (issue && !lock_q) begin
      lock_q       <= 1'b1;
      lock_src_q   <= grant_src;
      lock_wr_q    <= req_wr;
      lock_wstrb_q <= req_wstrb;
      lock_addr_q  <= req_addr;
      lock_wdata_q <= req_wdata;
    end
  end

  assign push_entry.src     = grant_src;
  assign push_entry.discard = 1'b0;

  arb_owner_fifo #(.DEPTH(OUTS_DEPTH)) u_owner_fifo (
    .clk        (clk),
    .resetn     (resetn),
    .push       (accept),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (flush & resetn),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .head       (head)
  );

  assign mem_req   = issue;
  assign mem_wr    = resetn & req_wr;
  assign mem_wstrb = resetn ? req_wstrb : 4'h0;
  assign mem_addr  = resetn ? req_addr  : 32'h0;
  assign mem_wdata = resetn ? req_wdata : 32'h0;

  assign inst_addr_ok = accept & (grant_src == SRC_INST);
  assign data_addr_ok = accept & (grant_src == SRC_DATA);
  assign data_data_ok = pop & (head.src == SRC_DATA);
  assign inst_data_ok = pop & (head.src == SRC_INST) & ~head.discard;

  assign inst_rdata = mem_rdata;
  assign data_rdata = mem_rdata;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_sram_port_arbiter;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        flush;
  logic        mem_req, mem_wr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;

  sram_port_arbiter #(.OUTS_DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .flush(flush),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: outstanding owners in a queue, a pending (unaccepted)
  // request snapshot, and which side wins the next tie.
  typedef struct { bit src; bit disc; } ent_t;
  ent_t        q[$];
  bit          m_pend, m_psrc, m_pwr;
  bit [3:0]    m_pwstrb;
  bit [31:0]   m_paddr, m_pwdata;
  bit          m_prio = 1'b1;
  bit          e_req, e_iaok, e_daok, e_idok, e_ddok, e_pop, e_src, e_wr;
  bit [3:0]    e_wstrb;
  bit [31:0]   e_addr, e_wdata;

  task automatic predict();
    bit ie, room, any, tie;
    ie   = inst_req && !flush;
    room = (q.size() < DEPTH) || mem_data_ok;
`ifdef ARB_RR_EN
    tie = m_prio;
`else
    tie = 1'b1;
`endif
    any = 1'b1;
    if (m_pend)               e_src = m_psrc;
    else if (data_req && ie)  e_src = tie;
    else if (data_req)        e_src = 1'b1;
    else if (ie)              e_src = 1'b0;
    else begin any = 1'b0; e_src = 1'b1; end
    if (m_pend) begin
      e_wr = m_pwr; e_wstrb = m_pwstrb; e_addr = m_paddr; e_wdata = m_pwdata;
    end else if (e_src) begin
      e_wr = data_wr; e_wstrb = data_wstrb; e_addr = data_addr; e_wdata = data_wdata;
    end else begin
      e_wr = 1'b0; e_wstrb = 4'h0; e_addr = inst_addr; e_wdata = 32'h0;
    end
    e_req  = resetn && any && room;
    e_iaok = e_req && mem_addr_ok && !e_src;
    e_daok = e_req && mem_addr_ok && e_src;
    e_pop  = resetn && mem_data_ok && q.size() > 0;
    e_ddok = 1'b0;
    e_idok = 1'b0;
    if (e_pop) begin
      e_ddok = q[0].src;
      e_idok = !q[0].src && !q[0].disc;
    end
  endtask

  task automatic commit();
    ent_t e;
    if (!resetn) begin
      q.delete(); m_pend = 1'b0; m_prio = 1'b1;
    end else begin
      if (e_pop) void'(q.pop_front());
      if (flush) foreach (q[i]) if (!q[i].src) q[i].disc = 1'b1;
      if (e_req && mem_addr_ok) begin
        e.src = e_src; e.disc = flush && !e_src;
        q.push_back(e);
        m_pend = 1'b0;
        m_prio = !e_src;
      end else if (e_req && !m_pend) begin
        m_pend = 1'b1; m_psrc = e_src; m_pwr = e_wr; m_pwstrb = e_wstrb;
        m_paddr = e_addr; m_pwdata = e_wdata;
      end
    end
  endtask

  // Inputs change 1 time unit after posedge; outputs are sampled at negedge.
  task automatic settle();
    predict();
    #4;
  endtask

  task automatic advance();
    @(posedge clk);
    commit();
    #1;
  endtask

  task automatic idle();
    inst_req = 0; inst_addr = 0; data_req = 0; data_wr = 0; data_wstrb = 0;
    data_addr = 0; data_wdata = 0; flush = 0; mem_addr_ok = 0; mem_data_ok = 0;
  endtask

  task automatic test_reset();
    resetn = 0;
    inst_req = 1; inst_addr = 32'h1111_0000; data_req = 1; data_wr = 1; data_wstrb = 4'hf;
    data_addr = 32'h2222_0000; data_wdata = 32'h3333_3333; flush = 0;
    mem_addr_ok = 1; mem_data_ok = 1; mem_rdata = 32'hCAFE_F00D;
    settle();
    n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
    n_checks++; if ({inst_addr_ok, data_addr_ok} !== 2'b00) begin n_fail++; $display("FAIL reset_addr_ok: got %b want 00", {inst_addr_ok, data_addr_ok}); end
    n_checks++; if ({inst_data_ok, data_data_ok} !== 2'b00) begin n_fail++; $display("FAIL reset_data_ok: got %b want 00", {inst_data_ok, data_data_ok}); end
    n_checks++; if ({mem_wr, mem_wstrb, mem_addr, mem_wdata} !== 69'h0) begin n_fail++; $display("FAIL reset_mem_fields: got %0h want 0", {mem_wr, mem_wstrb, mem_addr, mem_wdata}); end
    n_checks++; if (inst_rdata !== 32'hCAFE_F00D || data_rdata !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL reset_rdata: got %h/%h want cafef00d", inst_rdata, data_rdata); end
    advance();
    idle();
    settle();
    advance();
    resetn = 1;
    settle();
    n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle: got %b want 0", mem_req); end
    advance();
  endtask

  task automatic test_rr();
    idle(); inst_req = 1; inst_addr = 32'h100; data_req = 1; data_addr = 32'h200; mem_addr_ok = 1;
    for (int k = 0; k < 4; k++) begin
      settle();
      n_checks++; if ({data_addr_ok, inst_addr_ok} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL rr_grant%0d: got d/i=%b want %b", k, {data_addr_ok, inst_addr_ok}, (k % 2 == 0) ? 2'b10 : 2'b01); end
      advance();
    end
    idle(); mem_data_ok = 1;
    for (int k = 0; k < 4; k++) begin
      settle();
      n_checks++; if ({data_data_ok, inst_data_ok} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL rr_return%0d: got d/i=%b want %b", k, {data_data_ok, inst_data_ok}, (k % 2 == 0) ? 2'b10 : 2'b01); end
      advance();
    end
    idle();
  endtask

  task automatic test_priority();
    idle(); inst_req = 1; inst_addr = $urandom; data_req = 1; data_addr = $urandom; mem_addr_ok = 1;
    settle();
    n_checks++; if (data_addr_ok !== 1'b1 || inst_addr_ok !== 1'b0) begin n_fail++; $display("FAIL prio_grant: got d/i=%b%b want 10", data_addr_ok, inst_addr_ok); end
    n_checks++; if (mem_addr !== data_addr || mem_wr !== 1'b0) begin n_fail++; $display("FAIL prio_addr: got %h wr=%b want %h wr=0", mem_addr, mem_wr, data_addr); end
    advance();
    idle(); mem_data_ok = 1; mem_rdata = $urandom;
    settle();
    n_checks++; if ({data_data_ok, inst_data_ok} !== 2'b10) begin n_fail++; $display("FAIL prio_return: got d/i=%b want 10", {data_data_ok, inst_data_ok}); end
    n_checks++; if (data_rdata !== mem_rdata) begin n_fail++; $display("FAIL prio_rdata: got %h want %h", data_rdata, mem_rdata); end
    advance();
    idle();
  endtask

  task automatic test_lock();
    idle(); inst_req = 1; inst_addr = 32'hA000_0040;
    settle();
    n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'hA000_0040) begin n_fail++; $display("FAIL lock_c0: got req=%b addr=%h want 1/a0000040", mem_req, mem_addr); end
    advance();
    for (int c = 1; c <= 2; c++) begin
      data_req = 1; data_wr = 1; data_wstrb = 4'hf; data_addr = 32'hB000_0080; data_wdata = 32'h5A5A_5A5A;
      settle();
      n_checks++; if (mem_addr !== 32'hA000_0040 || mem_wr !== 1'b0 || data_addr_ok !== 1'b0) begin n_fail++; $display("FAIL lock_hold%0d: got addr=%h wr=%b daok=%b want a0000040/0/0", c, mem_addr, mem_wr, data_addr_ok); end
      advance();
    end
    mem_addr_ok = 1;
    settle();
    n_checks++; if (inst_addr_ok !== 1'b1 || data_addr_ok !== 1'b0 || mem_addr !== 32'hA000_0040) begin n_fail++; $display("FAIL lock_accept: got iaok=%b daok=%b addr=%h want 1/0/a0000040", inst_addr_ok, data_addr_ok, mem_addr); end
    advance();
    inst_req = 0;
    settle();
    n_checks++; if (data_addr_ok !== 1'b1 || mem_addr !== 32'hB000_0080 || mem_wr !== 1'b1 || mem_wstrb !== 4'hf || mem_wdata !== 32'h5A5A_5A5A) begin n_fail++; $display("FAIL lock_next: got daok=%b addr=%h wr=%b want 1/b0000080/1", data_addr_ok, mem_addr, mem_wr); end
    advance();
    idle(); mem_data_ok = 1;
    settle();
    n_checks++; if ({inst_data_ok, data_data_ok} !== 2'b10) begin n_fail++; $display("FAIL lock_ret0: got i/d=%b want 10", {inst_data_ok, data_data_ok}); end
    advance();
    settle();
    n_checks++; if ({inst_data_ok, data_data_ok} !== 2'b01) begin n_fail++; $display("FAIL lock_ret1: got i/d=%b want 01", {inst_data_ok, data_data_ok}); end
    advance();
    idle();
  endtask

  task automatic test_full();
    idle(); inst_req = 1; mem_addr_ok = 1;
    for (int i = 0; i < DEPTH; i++) begin
      inst_addr = 32'(i * 4);
      settle();
      n_checks++; if (inst_addr_ok !== 1'b1) begin n_fail++; $display("FAIL full_fill%0d: got %b want 1", i, inst_addr_ok); end
      advance();
    end
    settle();
    n_checks++; if (mem_req !== 1'b0 || inst_addr_ok !== 1'b0) begin n_fail++; $display("FAIL full_block: got req=%b iaok=%b want 0/0", mem_req, inst_addr_ok); end
    advance();
    mem_data_ok = 1;
    settle();
    n_checks++; if ({inst_data_ok, mem_req, inst_addr_ok} !== 3'b111) begin n_fail++; $display("FAIL full_swap: got idok/req/iaok=%b want 111", {inst_data_ok, mem_req, inst_addr_ok}); end
    advance();
    mem_data_ok = 0;
    settle();
    n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL full_still: got req=%b want 0", mem_req); end
    advance();
    inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
    for (int i = 0; i < DEPTH; i++) begin
      settle();
      n_checks++; if (inst_data_ok !== 1'b1) begin n_fail++; $display("FAIL full_drain%0d: got %b want 1", i, inst_data_ok); end
      advance();
    end
    settle();
    n_checks++; if ({inst_data_ok, data_data_ok} !== 2'b00) begin n_fail++; $display("FAIL empty_pop: got i/d=%b want 00", {inst_data_ok, data_data_ok}); end
    advance();
    idle();
  endtask

  task automatic test_flush();
    idle(); inst_req = 1; mem_addr_ok = 1;
    for (int i = 0; i < 2; i++) begin
      inst_addr = 32'h400 + 32'(i * 4);
      settle();
      n_checks++; if (inst_addr_ok !== 1'b1) begin n_fail++; $display("FAIL flush_issue%0d: got %b want 1", i, inst_addr_ok); end
      advance();
    end
    flush = 1;
    settle();
    n_checks++; if (mem_req !== 1'b0 || inst_addr_ok !== 1'b0) begin n_fail++; $display("FAIL flush_nogrant: got req=%b iaok=%b want 0/0", mem_req, inst_addr_ok); end
    advance();
    idle(); mem_data_ok = 1;
    for (int i = 0; i < 2; i++) begin
      settle();
      n_checks++; if (inst_data_ok !== 1'b0) begin n_fail++; $display("FAIL flush_drop%0d: got %b want 0", i, inst_data_ok); end
      advance();
    end
    idle(); inst_req = 1; inst_addr = 32'h800; mem_addr_ok = 1;
    settle();
    n_checks++; if (inst_addr_ok !== 1'b1) begin n_fail++; $display("FAIL flush_refetch: got %b want 1", inst_addr_ok); end
    advance();
    idle(); mem_data_ok = 1; mem_rdata = 32'h0BAD_BEEF;
    settle();
    n_checks++; if (inst_data_ok !== 1'b1 || inst_rdata !== 32'h0BAD_BEEF) begin n_fail++; $display("FAIL flush_return: got %b/%h want 1/0badbeef", inst_data_ok, inst_rdata); end
    advance();
    idle();
  endtask

  task automatic test_interleave();
    idle(); inst_req = 1; inst_addr = 32'hC00; mem_addr_ok = 1;
    settle();
    n_checks++; if (inst_addr_ok !== 1'b1) begin n_fail++; $display("FAIL il_inst: got %b want 1", inst_addr_ok); end
    advance();
    idle(); data_req = 1; data_wr = 1; data_wstrb = 4'h3; data_addr = 32'hD00; data_wdata = 32'h1234_5678; mem_addr_ok = 1;
    settle();
    n_checks++; if (data_addr_ok !== 1'b1 || mem_wr !== 1'b1 || mem_wstrb !== 4'h3 || mem_wdata !== 32'h1234_5678) begin n_fail++; $display("FAIL il_write: got daok=%b wr=%b strb=%h wdata=%h want 1/1/3/12345678", data_addr_ok, mem_wr, mem_wstrb, mem_wdata); end
    advance();
    data_wr = 0; data_addr = 32'hD04;
    settle();
    n_checks++; if (data_addr_ok !== 1'b1 || mem_wr !== 1'b0 || mem_addr !== 32'hD04) begin n_fail++; $display("FAIL il_read: got daok=%b wr=%b addr=%h want 1/0/d04", data_addr_ok, mem_wr, mem_addr); end
    advance();
    idle(); mem_data_ok = 1;
    for (int k = 0; k < 3; k++) begin
      mem_rdata = $urandom;
      settle();
      n_checks++; if ({inst_data_ok, data_data_ok} !== ((k == 0) ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL il_route%0d: got i/d=%b want %b", k, {inst_data_ok, data_data_ok}, (k == 0) ? 2'b10 : 2'b01); end
      advance();
    end
    idle();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      inst_req    = ($urandom % 3) != 0;
      inst_addr   = $urandom;
      data_req    = ($urandom % 2) != 0;
      data_wr     = ($urandom % 2) != 0;
      data_wstrb  = 4'($urandom);
      data_addr   = $urandom;
      data_wdata  = $urandom;
      flush       = ($urandom % 10) == 0;
      mem_addr_ok = ($urandom % 2) != 0;
      mem_data_ok = ($urandom % 3) == 0;
      mem_rdata   = $urandom;
      settle();
      n_checks++; if (mem_req !== e_req) begin n_fail++; $display("FAIL rnd_req@%0d: got %b want %b", n, mem_req, e_req); end
      n_checks++; if ({inst_addr_ok, data_addr_ok} !== {e_iaok, e_daok}) begin n_fail++; $display("FAIL rnd_addr_ok@%0d: got %b want %b", n, {inst_addr_ok, data_addr_ok}, {e_iaok, e_daok}); end
      n_checks++; if ({inst_data_ok, data_data_ok} !== {e_idok, e_ddok}) begin n_fail++; $display("FAIL rnd_data_ok@%0d: got %b want %b", n, {inst_data_ok, data_data_ok}, {e_idok, e_ddok}); end
      n_checks++; if (inst_rdata !== mem_rdata || data_rdata !== mem_rdata) begin n_fail++; $display("FAIL rnd_rdata@%0d: got %h/%h want %h", n, inst_rdata, data_rdata, mem_rdata); end
      if (e_req) begin
        n_checks++; if ({mem_wr, mem_wstrb, mem_addr, mem_wdata} !== {e_wr, e_wstrb, e_addr, e_wdata}) begin n_fail++; $display("FAIL rnd_fields@%0d: got %b/%h/%h/%h want %b/%h/%h/%h", n, mem_wr, mem_wstrb, mem_addr, mem_wdata, e_wr, e_wstrb, e_addr, e_wdata); end
      end
      advance();
    end
    idle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    resetn = 0;
    mem_rdata = 0;
    @(posedge clk);
    #1;
    test_reset();
`ifdef ARB_RR_EN
    test_rr();
`endif
    test_priority();
    test_lock();
    test_full();
    test_flush();
    test_interleave();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_port_arbiter.md
SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

Interface
REQ-001 SHALL have parameter OUTS_DEPTH, default 4, giving the maximum outstanding accepted transactions (power of two, 2..8).
REQ-002 clk  in  1  clock; all state on posedge.
REQ-003 resetn  in  1  synchronous, active-low reset.
REQ-004 inst_req  in  1  fetch request (read only).
REQ-005 inst_addr  in  32  fetch address.
REQ-006 inst_addr_ok  out  1  fetch request accepted this cycle.
REQ-007 inst_data_ok  out  1  fetch data returned this cycle.
REQ-008 inst_rdata  out  32  fetch read data.
REQ-009 data_req  in  1  MEM-stage request.
REQ-010 data_wr  in  1  1 = write.
REQ-011 data_wstrb  in  4  write byte enables.
REQ-012 data_addr  in  32  MEM address.
REQ-013 data_wdata  in  32  write data.
REQ-014 data_addr_ok  out  1  MEM request accepted.
REQ-015 data_data_ok  out  1  MEM read data / write ack returned.
REQ-016 data_rdata  out  32  MEM read data.
REQ-017 flush  in  1  pipeline flush (exception/ertn); one-cycle pulse.
REQ-018 mem_req, mem_wr, mem_wstrb[3:0], mem_addr[31:0], mem_wdata[31:0]  out  shared-port request, same meaning as data_*.
REQ-019 mem_addr_ok, mem_data_ok  in  1  shared-port handshakes; mem_rdata  in  32  shared-port read data.

Function
REQ-020 Shared port SHALL return mem_data_ok strictly in acceptance order; arbiter SHALL track owners in an OUTS_DEPTH-entry FIFO of {src, discard}.
REQ-021 Grant (default build): data over inst; inst granted only when data_req=0.
REQ-022 Once mem_req=1 without mem_addr_ok, grant and mem_* fields SHALL hold until mem_addr_ok (lock); lock clears on handshake.
REQ-023 mem_req = granted requester's req AND FIFO not full; mem_addr_ok SHALL be forwarded only to the granted requester, other addr_ok = 0.
REQ-024 mem_req & mem_addr_ok SHALL push {src, discard=0}; mem_data_ok SHALL pop head.
REQ-025 Popped src=1 SHALL pulse data_data_ok; src=0 with discard=0 SHALL pulse inst_data_ok; src=0 with discard=1 SHALL pulse neither.
REQ-026 inst_rdata and data_rdata SHALL both equal mem_rdata combinationally; response path latency zero cycles.
REQ-027 Simultaneous push and pop SHALL leave count unchanged; pop of a full FIFO plus push in same cycle allowed.
REQ-028 FIFO full: mem_req=0, both addr_ok=0, lock unaffected.
REQ-029 mem_data_ok with empty FIFO SHALL be ignored (no output pulse, no pointer change).
REQ-030 flush SHALL set discard on every src=0 entry in the FIFO and on any inst entry pushed that cycle; inst_req SHALL not win new grant during flush cycle (locked grant still completes).
REQ-031 Pointers SHALL wrap modulo OUTS_DEPTH; count width clog2(OUTS_DEPTH)+1.

Reset
REQ-032 On resetn=0: FIFO empty, lock clear, round-robin pointer = data; all outputs 0 except rdata (follows mem_rdata).

Configuration
REQ-033 ARB_RR_EN defined: grant alternates on each accepted handshake when both request (round-robin, pointer starts at data); undefined: fixed priority per REQ-021.

Structure
REQ-034 Shared package SHALL hold SRC_INST=0/SRC_DATA=1 constants and the owner-entry typedef.
REQ-035 Owner FIFO SHALL be a sub-module named arb_owner_fifo (push, pop, flush-mark, full, empty, head).

Verification
REQ-036 inst_req and data_req both high, mem_addr_ok=1 -> data granted, data_addr_ok=1, inst_addr_ok=0 (fixed build).
REQ-037 Grant inst with mem_addr_ok=0 for 3 cycles, data_req rises cycle 1 -> mem_addr stays inst_addr until accepted.
REQ-038 Issue 4 inst reads, no data_ok -> 5th request sees mem_req=0; then data_ok + new req same cycle -> count stays 4.
REQ-039 2 inst reads outstanding, flush, then 2 mem_data_ok -> no inst_data_ok; later fetch returns normally.
REQ-040 Interleave inst read, data write, data read -> data_ok routed inst, data, data in order.
REQ-041 ARB_RR_EN, both requesting 4 accepts -> grants D,I,D,I.
